// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 8-tap time-multiplexed FIR around one shared MAC.
// Handshaked sample in, one filtered result out per accepted sample.
module fir_mac_sequencer #(
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int TAPS   = 8,
  localparam int TW     = $clog2(TAPS),
  localparam int ACC_W  = DATA_W + COEF_W + TW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  input  logic              coef_we,
  input  logic [TW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy
);

  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [DATA_W-1:0] d [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [PW-1:0]     prod;
  logic [TW-1:0]            tap;
  logic                     last;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign last     = (tap == TW'(TAPS - 1));
  assign prod     = d[tap] * c[tap];
  assign sum      = acc + {{TW{prod[PW-1]}}, prod};

  // State register; reset aborts any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept, step through all taps, wait for consumer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = MAC;
      MAC:     if (last)      state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Delay line, coefficient table, MAC and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        d[k] <= '0;
        c[k] <= COEF_W'(1);
      end
      acc       <= '0;
      tap       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (coef_we) c[coef_addr] <= coef_wdata;
        if (in_valid) begin
          for (int k = TAPS - 1; k > 0; k--) d[k] <= d[k-1];
          d[0] <= in_data;
          acc  <= '0;
          tap  <= '0;
        end
      end
      if (state_q == MAC) begin
        acc <= sum;
        tap <= tap + TW'(1);
        if (last) begin
          out_data  <= sum;
          out_valid <= 1'b1;
        end
      end
      if (state_q == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench for the FIR MAC sequencer.
// Expected results come from a behavioural FIR model in the bench.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [18:0] out_data;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [7:0]  coef_wdata = '0;
  logic        busy;

  fir_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int q[$];
  int md[8];
  int mc[8];
  int acc_cyc = 0;
  bit seen = 0;

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      md[k] = 0;
      mc[k] = 1;
    end
    q.delete();
    seen = 0;
  endtask

  task automatic monitor();
    int got, exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !seen) begin
        seen = 1;
        total++;
        if (cyc - acc_cyc !== 8)
          $display("FAIL latency: got %0d cycles, want 8", cyc - acc_cyc);
        else passed++;
      end
      if (rst_n && out_valid && out_ready) begin
        seen = 0;
        total++;
        got = $signed(out_data);
        if (q.size() == 0) begin
          $display("FAIL unexpected_out: got %0d, none expected", got);
        end else begin
          exp = q.pop_front();
          if (got !== exp)
            $display("FAIL result: got %0d, want %0d", got, exp);
          else passed++;
        end
      end
    end
  endtask

  task automatic send(input int x, input bit we, input int a, input int v,
                      output int ac);
    int n, y;
    n = 0;
    ac = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0, want 1");
    end else begin
      in_valid   = 1'b1;
      in_data    = 8'(x);
      coef_we    = we;
      coef_addr  = 3'(a);
      coef_wdata = 8'(v);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      ac = cyc;
      acc_cyc = cyc;
      if (we) mc[a] = v;
      for (int k = 7; k > 0; k--) md[k] = md[k-1];
      md[0] = x;
      y = 0;
      for (int k = 0; k < 8; k++) y += md[k] * mc[k];
      q.push_back(y);
    end
  endtask

  task automatic wcoef(input int a, input int v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 3'(a);
    coef_wdata = 8'(v);
    if (in_ready) mc[a] = v;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (q.size() != 0)
      $display("FAIL drain: got %0d pending, want 0", q.size());
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0)
        $display("FAIL reset_vals: got v=%b d=%0h b=%b, want 0 0 0",
                 out_valid, out_data, busy);
      else passed++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    else passed++;
  endtask

  task automatic test_default_coefs();
    int a1, a2, a3;
    out_ready = 1'b1;
    send(1, 0, 0, 0, a1);
    send(2, 0, 0, 0, a2);
    send(3, 0, 0, 0, a3);
    drain();
    total++;
    if (a2 - a1 !== 10 || a3 - a2 !== 10)
      $display("FAIL accept_spacing: got %0d,%0d, want 10,10",
               a2 - a1, a3 - a2);
    else passed++;
  endtask

  task automatic test_impulse();
    int ac;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) wcoef(k, k);
    send(1, 1, 7, 7, ac);
    for (int i = 0; i < 8; i++) send(0, 0, 0, 0, ac);
    drain();
  endtask

  task automatic test_backpressure();
    int ac, n;
    logic [18:0] held;
    do_reset();
    out_ready = 1'b0;
    send(3, 0, 0, 0, ac);
    wcoef(0, 50);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!out_valid) $display("FAIL bp_valid: got 0, want 1");
    else passed++;
    held = out_data;
    in_valid = 1'b1;
    in_data  = 8'd77;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0)
        $display("FAIL bp_hold: got v=%b d=%0h r=%b, want 1 %0h 0",
                 out_valid, out_data, in_ready, held);
      else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_data !== held)
      $display("FAIL bp_after: got v=%b d=%0h, want 0 %0h",
               out_valid, out_data, held);
    else passed++;
    send(4, 0, 0, 0, ac);
    drain();
  endtask

  task automatic test_signed();
    int ac;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) wcoef(k, -128);
    for (int i = 0; i < 8; i++) send(-128, 0, 0, 0, ac);
    drain();
    total++;
    if ($signed(out_data) !== 19'sd131072)
      $display("FAIL signed_max: got %0d, want 131072", $signed(out_data));
    else passed++;
    wcoef(0, 127);
    for (int k = 1; k < 8; k++) wcoef(k, 0);
    send(-128, 0, 0, 0, ac);
    drain();
    total++;
    if ($signed(out_data) !== -19'sd16256)
      $display("FAIL signed_min: got %0d, want -16256", $signed(out_data));
    else passed++;
  endtask

  task automatic test_reset_mid_mac();
    int ac;
    out_ready = 1'b1;
    wcoef(0, 9);
    send(7, 0, 0, 0, ac);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL async_reset: got b=%b v=%b, want 0 0", busy, out_valid);
    else passed++;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0)
        $display("FAIL mid_reset_valid: got %b, want 0", out_valid);
      else passed++;
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    send(5, 0, 0, 0, ac);
    drain();
    total++;
    if ($signed(out_data) !== 19'sd5)
      $display("FAIL post_reset: got %0d, want 5", $signed(out_data));
    else passed++;
  endtask

  initial begin
    model_clear();
    fork
      monitor();
    join_none
    test_reset();
    test_default_coefs();
    test_impulse();
    test_backpressure();
    test_signed();
    test_reset_mid_mac();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed 8-tap FIR engine with a single shared multiply-accumulate unit. The block holds the sample delay line and a writable coefficient table. For each accepted sample it steps the tap select through all taps, accumulates the products, and presents one filtered result. It is the sequencing controller placed around the shift-register / tap-mux / coefficient-lookup / MAC datapath, and it replaces the free-running select logic with a handshaked state machine.

## Interface
- DATA_W, 8, sample width (signed two's complement)
- COEF_W, 8, coefficient width (signed two's complement)
- TAPS, 8, number of taps; power of two, 2..16
- ACC_W (derived, not overridable), DATA_W+COEF_W+log2(TAPS), accumulator/result width
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample; high exactly in IDLE
- in_data  in  DATA_W  input sample
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  filtered result, signed
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS)  coefficient index
- coef_wdata  in  COEF_W  coefficient value
- busy  out  1  high in MAC and HOLD

## Operation
- **Storage**
  - Delay line d[0..TAPS-1]: d[0] holds the newest sample.
  - Coefficient table c[0..TAPS-1].
  - Result: y = sum over k of c[k]·d[k], which is y[n] = Σ c[k]·x[n-k].
- **Reset** (rst_n low, takes effect immediately):
  - state=IDLE, all d[k]=0, all c[k]=1, accumulator=0, tap index=0.
  - out_valid=0, out_data=0, busy=0.
  - in_ready=1 once rst_n is high.
- **IDLE**
  - in_ready=1.
  - On in_valid && in_ready:
    - shift d[k]<=d[k-1] for k≥1, d[0]<=in_data;
    - acc<=0, tap<=0;
    - go to MAC.
- **MAC** (TAPS cycles)
  - Each edge: acc <= acc + sext(d[tap]·c[tap]); tap <= tap+1.
  - On the edge where tap==TAPS-1:
    - out_data <= final sum (including this product);
    - out_valid<=1;
    - go to HOLD.
- **HOLD**
  - out_valid and out_data stay stable until out_ready is high at an edge.
  - On that edge: out_valid<=0, go to IDLE.
  - out_data keeps its last value after the handshake.
- **Coefficient writes**
  - Honoured only when state==IDLE at the edge: c[coef_addr]<=coef_wdata.
  - In MAC or HOLD, the write is silently dropped.
- **Simultaneous write and sample accept in IDLE:** both take effect. The MAC run that follows uses the new coefficient.
- **Arithmetic**
  - Signed DATA_W×COEF_W product, sign-extended to ACC_W.
  - ACC_W is sized so that no overflow is possible; no saturation or rounding.
- in_valid while not in IDLE is ignored: the sample is not consumed and in_ready stays low.
- **Reset mid-operation:** the run in progress is aborted with no output, and the delay line and coefficients are cleared as in Reset.

## Timing
- Sample accepted at edge E0.
- MAC products accumulate at edges E1..E_TAPS.
- out_valid is high from after edge E_TAPS; latency is TAPS cycles from accept to result.
- If out_ready is already high in the first HOLD cycle, the handshake completes at E_TAPS+1. in_ready is high after E_TAPS+1, so the next accept is possible at E_TAPS+2.
- Maximum throughput: one sample per TAPS+2 cycles. Each cycle of out_ready low extends HOLD by one cycle.
- in_ready and busy are functions of the registered state only; no combinational path from in_valid or out_ready.

## Test plan
- **Reset values:** hold rst_n low 3 cycles, then release.
  - During reset: out_valid=0, out_data=0, busy=0.
  - After release: in_ready=1.
  - Assert rst_n low between edges: state clears immediately, without waiting for a clock edge.
- **Default coefficients (all 1):** send samples 1, 2, 3 with out_ready=1.
  - Outputs are 1, 3, 6.
  - Each out_valid rises exactly 8 cycles after its accept edge.
  - Accepts are spaced 10 cycles apart.
- **Impulse response:** in IDLE, write c[k]=k for k=0..7. Send 1 followed by 8 zeros.
  - Outputs are 0, 1, 2, 3, 4, 5, 6, 7, 0.
- **Backpressure and dropped writes:**
  - With out_ready=0 for 20 cycles after out_valid, out_valid and out_data stay stable and in_ready=0.
  - Offered in_valid samples are not consumed.
  - A coef_we issued during MAC does not change subsequent results.
- **Signed extremes:** set all c[k]=-128 and send -128 eight times.
  - The eighth output is +131072; no wrap occurs in the 19-bit result.
  - Then set c[0]=127, c[1..7]=0, send -128: output is -16256.
- **Reset mid-MAC:** pull rst_n low 4 cycles after an accept.
  - out_valid never rises.
  - After release, a single sample 5 with default coefficients produces 5, confirming the delay line was cleared.
